freq_meter: RTL

Measures the frequency and period of a slow digital signal against the system clock. A typical input is a clock produced by the divider or any external square wave. The input is synchronized, and its rising edges are counted over a fixed gate window of system-clock cycles. Two results are reported with one-cycle valid strobes: edges per window, and the system-clock cycles between consecutive rising edges. The block is used as a self-check and debug monitor beside the clock-generation logic.

---
 rtl/freq_meter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Frequency and period monitor for a slow, asynchronous square wave.
// It counts rising edges per fixed gate window and measures the clk_in cycles between consecutive edges.
module freq_meter #(
   parameter int SYS_CLK     = 10000000,
   parameter int GATE_CYCLES = SYS_CLK,
   parameter int CNT_W       = 32
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             meas_in,
   input  logic             enable,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             busy
);

   localparam int               GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   if (GATE_CYCLES < 4) begin : g_bad_gate
      $error("freq_meter: GATE_CYCLES must be at least 4");
   end

   typedef enum logic {IDLE, GATE} state_t;

   state_t           state_q, state_d;
   logic             s1, s2, s3;
   logic             rise;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             ovf;
   logic             win_close;
   logic             edge_sat;
   logic [CNT_W-1:0] per_cnt;
   logic             armed;

   assign rise      = s2 & ~s3;
   assign win_close = (state_q == GATE) && (gate_cnt == GATE_LAST);
   assign edge_sat  = (edge_cnt == CNT_MAX);
   assign busy      = (state_q == GATE);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= meas_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A window that closes with enable low still reports; it simply does not restart.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = GATE;
         GATE:    if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         ovf        <= 1'b0;
         freq       <= '0;
         overflow   <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= win_close;
         if (win_close) begin
            freq     <= (rise && !edge_sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
            overflow <= ovf | (rise & edge_sat);
         end
         if (state_q == GATE && enable && !win_close) begin
            gate_cnt <= gate_cnt + GW'(1);
            if (rise) begin
               if (edge_sat) ovf      <= 1'b1;
               else          edge_cnt <= edge_cnt + CNT_W'(1);
            end
         end else begin
            // idle, abort and window close all restart the window from zero
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt      <= '0;
         armed        <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            per_cnt <= '0;
            armed   <= 1'b0;
         end else if (rise) begin
            per_cnt <= CNT_W'(1);
            armed   <= 1'b1;
            if (armed) begin
               period       <= per_cnt;
               period_valid <= 1'b1;
            end
         end else if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_W'(1);
         end
      end
   end

endmodule
